lane_polarity_decoder: RTL and testbench

//  Receive-side partner of the 8-lane mixed BUF/NOT gate bus: captures the lane

---
 rtl/lane_bus_pkg.sv | 6 +
 rtl/lane_toggle_counter.sv | 19 +
 rtl/lane_polarity_decoder.sv | 99 +++++++++
 tb/tb_lane_polarity_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_bus_pkg.sv
// lane_bus_pkg: shared lane count, default inversion mask and read FSM states for the lane bus
package lane_bus_pkg;
    localparam int LANES = 8;
    localparam logic [LANES-1:0] DEFAULT_INV_MASK = 8'hE1;
    typedef enum logic [1:0] {IDLE, LATCH, RESP} rd_state_t;
endpackage

// File: rtl/lane_toggle_counter.sv
// lane_toggle_counter: saturating per-lane toggle counter with synchronous clear
module lane_toggle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/lane_polarity_decoder.sv
// lane_polarity_decoder: restores inverted lanes, counts per-lane toggles, serves counter reads
module lane_polarity_decoder
    import lane_bus_pkg::*;
#(
    parameter int               WIDTH    = LANES,
    parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(DEFAULT_INV_MASK),
    parameter int               CNT_W    = 8,
    localparam int              IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             busy
);
    logic [WIDTH-1:0] last;
    logic             hist;
    logic [WIDTH-1:0] inc;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] rd_tbl [2**IDX_W];
    logic [IDX_W-1:0] idx;
    rd_state_t        state;

    assign inc = {WIDTH{in_valid && hist}} & (din ^ last);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lane_toggle_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .inc  (inc[i]),
            .cnt  (cnt[i])
        );
    end

    // Out-of-range lane indices read back as zero
    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_tbl
        if (i < WIDTH) begin : g_real
            assign rd_tbl[i] = cnt[i];
        end else begin : g_zero
            assign rd_tbl[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            last      <= '0;
            hist      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout <= din ^ INV_MASK;
                last <= din;
                hist <= 1'b1;
            end else if (clr) begin
                hist <= 1'b0;
            end
        end
    end

    // LATCH samples the counters before this edge's increment or clear lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: if (rd_req) begin
                    idx   <= rd_idx;
                    busy  <= 1'b1;
                    state <= LATCH;
                end
                LATCH: begin
                    rd_data <= rd_tbl[idx];
                    rd_ack  <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    rd_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lane_polarity_decoder.sv
// tb_lane_polarity_decoder: randomized and directed checks of two decoder instances (8-bit and 2-bit counters)
module tb_lane_polarity_decoder;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic [7:0] din = 0;
    logic       clr = 0;
    logic       rd_req = 0;
    logic [2:0] rd_idx = 0;
    logic       out_valid, rd_ack, busy;
    logic [7:0] dout, rd_data;
    logic       out_valid2, rd_ack2, busy2;
    logic [7:0] dout2;
    logic [1:0] rd_data2;

    int errors = 0;
    int checks = 0;

    int         cnt8 [8];
    int         cnt2 [8];
    logic [7:0] m_last;
    bit         m_hist;
    int         acc;
    int         cyc = 0;
    int         m_idx;
    logic [7:0] e_rd8;
    logic [1:0] e_rd2;
    logic       e_ov, e_ack, e_busy;
    logic [7:0] e_dout;

    always #5 clk = ~clk;

    lane_polarity_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .out_valid(out_valid), .dout(dout), .clr(clr), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_ack(rd_ack), .rd_data(rd_data), .busy(busy)
    );

    lane_polarity_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
        .out_valid(out_valid2), .dout(dout2), .clr(clr), .rd_req(rd_req),
        .rd_idx(rd_idx), .rd_ack(rd_ack2), .rd_data(rd_data2), .busy(busy2)
    );

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            cnt8[i] = 0;
            cnt2[i] = 0;
        end
        m_last = 0; m_hist = 0; acc = -100;
        e_rd8 = 0; e_rd2 = 0; e_ov = 0; e_dout = 0; e_ack = 0; e_busy = 0;
    endtask

    // One clock: drive inputs, take the edge, advance the reference model
    task automatic cyc_step(input logic v, input logic [7:0] d, input logic c,
                            input logic rq, input logic [2:0] ri);
        in_valid = v; din = d; clr = c; rd_req = rq; rd_idx = ri;
        @(posedge clk);
        if (acc >= 0 && cyc == acc + 1) begin
            e_rd8 = 8'(cnt8[m_idx]);
            e_rd2 = 2'(cnt2[m_idx]);
        end
        e_ov = v;
        if (v) e_dout = d ^ 8'hE1;
        if (c) begin
            for (int i = 0; i < 8; i++) begin
                cnt8[i] = 0;
                cnt2[i] = 0;
            end
        end else if (v && m_hist) begin
            for (int i = 0; i < 8; i++)
                if (d[i] != m_last[i]) begin
                    cnt8[i] = (cnt8[i] < 255) ? cnt8[i] + 1 : 255;
                    cnt2[i] = (cnt2[i] < 3) ? cnt2[i] + 1 : 3;
                end
        end
        if (v) begin
            m_last = d;
            m_hist = 1;
        end else if (c) begin
            m_hist = 0;
        end
        if (rq && !(acc >= 0 && cyc <= acc + 2)) begin
            acc = cyc;
            m_idx = ri;
        end
        e_ack  = (acc >= 0 && cyc == acc + 1);
        e_busy = (acc >= 0 && (cyc == acc || cyc == acc + 1));
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; din = 0; clr = 0; rd_req = 0; rd_idx = 0;
        model_reset();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Issues a request and returns the cycles until rd_ack (-1 if none), then lets RESP finish
    task automatic read_lane(input logic [2:0] i, output int lat);
        cyc_step(0, 0, 0, 1, i);
        lat = -1;
        for (int k = 1; k <= 8; k++)
            if (lat < 0) begin
                if (rd_ack) lat = k;
                else cyc_step(0, 0, 0, 0, 0);
            end
        cyc_step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        int lat;
        do_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack got=%b exp=0", rd_ack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        cyc_step(1, 8'h00, 0, 0, 0);
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got=%b exp=1", out_valid); end
        if (dout !== 8'hE1) begin errors++; $display("FAIL first_dout got=%h exp=e1", dout); end
        for (int l = 0; l < 8; l++) begin
            read_lane(3'(l), lat);
            checks += 2;
            if (lat != 2) begin errors++; $display("FAIL reset_read_latency lane=%0d got=%0d exp=2", l, lat); end
            if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_count lane=%0d got=%0d exp=0", l, rd_data); end
        end
    endtask

    task automatic test_pattern();
        int lat;
        do_reset();
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(1, 8'hFF, 0, 0, 0);
        checks++;
        if (dout !== 8'h1E) begin errors++; $display("FAIL pattern_dout got=%h exp=1e", dout); end
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(0, 8'h55, 0, 0, 0);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
        if (dout !== 8'hE1) begin errors++; $display("FAIL idle_dout_hold got=%h exp=e1", dout); end
        for (int l = 0; l < 8; l++) begin
            read_lane(3'(l), lat);
            checks += 3;
            if (lat != 2) begin errors++; $display("FAIL pattern_latency lane=%0d got=%0d exp=2", l, lat); end
            if (rd_data !== 8'd2) begin errors++; $display("FAIL pattern_count lane=%0d got=%0d exp=2", l, rd_data); end
            if (rd_data2 !== 2'd2) begin errors++; $display("FAIL pattern_count2 lane=%0d got=%0d exp=2", l, rd_data2); end
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        for (int i = 0; i < 300; i++) cyc_step(1, (i % 2) ? 8'h08 : 8'h00, 0, 0, 0);
        read_lane(3'd3, lat);
        checks += 2;
        if (rd_data2 !== 2'd3) begin errors++; $display("FAIL sat2_lane3 got=%0d exp=3", rd_data2); end
        if (rd_data !== 8'd255) begin errors++; $display("FAIL sat8_lane3 got=%0d exp=255", rd_data); end
        read_lane(3'd4, lat);
        checks += 2;
        if (rd_data2 !== 2'd0) begin errors++; $display("FAIL sat2_lane4 got=%0d exp=0", rd_data2); end
        if (rd_data !== 8'd0) begin errors++; $display("FAIL sat8_lane4 got=%0d exp=0", rd_data); end
    endtask

    task automatic test_collision();
        int lat;
        do_reset();
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(1, 8'h02, 0, 0, 0);
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(1, 8'h02, 0, 0, 0);
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(0, 8'h00, 0, 1, 3'd1);
        cyc_step(1, 8'h02, 0, 0, 0);
        checks += 2;
        if (rd_ack !== 1'b1) begin errors++; $display("FAIL collide_ack got=%b exp=1", rd_ack); end
        if (rd_data !== 8'd4) begin errors++; $display("FAIL collide_pre_inc got=%0d exp=4", rd_data); end
        cyc_step(0, 8'h00, 0, 0, 0);
        read_lane(3'd1, lat);
        checks++;
        if (rd_data !== 8'd5) begin errors++; $display("FAIL collide_after got=%0d exp=5", rd_data); end
    endtask

    task automatic test_clr();
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) cyc_step(1, (i % 2) ? 8'h01 : 8'h00, 0, 0, 0);
        read_lane(3'd0, lat);
        checks++;
        if (rd_data !== 8'd7) begin errors++; $display("FAIL clr_precount got=%0d exp=7", rd_data); end
        cyc_step(1, 8'h01, 1, 0, 0);
        cyc_step(1, 8'h00, 0, 0, 0);
        read_lane(3'd0, lat);
        checks++;
        if (rd_data !== 8'd1) begin errors++; $display("FAIL clr_with_valid got=%0d exp=1", rd_data); end
        cyc_step(0, 8'h00, 0, 1, 3'd0);
        cyc_step(0, 8'h00, 1, 0, 0);
        checks++;
        if (rd_data !== 8'd1) begin errors++; $display("FAIL clr_latch_preclear got=%0d exp=1", rd_data); end
        cyc_step(0, 8'h00, 0, 0, 0);
        cyc_step(1, 8'h01, 0, 0, 0);
        read_lane(3'd0, lat);
        checks++;
        if (rd_data !== 8'd0) begin errors++; $display("FAIL clr_first_after got=%0d exp=0", rd_data); end
    endtask

    task automatic test_busy_abort();
        int acks;
        do_reset();
        cyc_step(1, 8'h00, 0, 0, 0);
        cyc_step(1, 8'h24, 0, 0, 0);
        cyc_step(1, 8'h00, 0, 0, 0);
        acks = 0;
        cyc_step(0, 8'h00, 0, 1, 3'd2);
        cyc_step(0, 8'h00, 0, 1, 3'd5);
        if (rd_ack) acks++;
        cyc_step(0, 8'h00, 0, 1, 3'd5);
        if (rd_ack) acks++;
        for (int i = 0; i < 5; i++) begin
            cyc_step(0, 8'h00, 0, 0, 0);
            if (rd_ack) acks++;
        end
        checks += 3;
        if (acks != 1) begin errors++; $display("FAIL busy_single_ack got=%0d exp=1", acks); end
        if (rd_data !== 8'd2) begin errors++; $display("FAIL busy_data got=%0d exp=2", rd_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got=%b exp=0", busy); end
        cyc_step(0, 8'h00, 0, 1, 3'd5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_latch got=%b exp=1", busy); end
        rst_n = 0;
        #2;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (rd_ack !== 1'b0) begin errors++; $display("FAIL abort_ack got=%b exp=0", rd_ack); end
        do_reset();
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            cyc_step(0, 8'h00, 0, 0, 0);
            if (rd_ack) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc_step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 2) == 0), 3'($urandom));
            checks += 7;
            if (out_valid !== e_ov) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov); end
            if (dout !== e_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end
            if (rd_ack !== e_ack) begin errors++; $display("FAIL rnd_rd_ack cyc=%0d got=%b exp=%b", cyc, rd_ack, e_ack); end
            if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
            if (rd_data !== e_rd8) begin errors++; $display("FAIL rnd_rd_data cyc=%0d got=%0d exp=%0d", cyc, rd_data, e_rd8); end
            if (rd_data2 !== e_rd2) begin errors++; $display("FAIL rnd_rd_data2 cyc=%0d got=%0d exp=%0d", cyc, rd_data2, e_rd2); end
            if (rd_ack2 !== e_ack) begin errors++; $display("FAIL rnd_rd_ack2 cyc=%0d got=%b exp=%b", cyc, rd_ack2, e_ack); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pattern();
        test_saturation();
        test_collision();
        test_clr();
        test_busy_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
